fetch_stage: RTL and testbench

Instruction-fetch stage of the ARMv3 pipelined processor. Holds the program counter, drives the word address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register with PC+8 and a valid bit. Handles stalls, flushes, and taken-branch redirects from the hazard and execute logic, and halts fetch when PC leaves the instruction memory window.

---
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/execute control inputs, the instruction-memory
// read port and the IF/ID pipeline register outputs.
interface fetch_stage_if;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        BranchTakenE;
  logic [31:0] BranchTargetE;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCPlus8D;
  logic        ValidD;
  logic        Halted;
  logic [31:0] FetchCount;

  // Side that owns the pipeline controls and the instruction memory
  modport master (
    output StallF, StallD, FlushD, BranchTakenE, BranchTargetE, InstrF,
    input  PCF, InstrD, PCPlus8D, ValidD, Halted, FetchCount
  );

  // The fetch stage itself
  modport slave (
    input  StallF, StallD, FlushD, BranchTakenE, BranchTargetE, InstrF,
    output PCF, InstrD, PCPlus8D, ValidD, Halted, FetchCount
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register,
// branch redirect, stall/flush handling and halt on leaving the memory window.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0000_01FC
) (
  input  logic     CLK,
  input  logic     Reset,
  fetch_stage_if.slave bus
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        in_range;

  assign in_range = (pc_q <= IMEM_LIMIT);

  // Next PC and run/halt state; a redirect always wins and is the only way out of HALT
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (bus.BranchTakenE) begin
      pc_d    = {bus.BranchTargetE[31:2], 2'b00};
      state_d = RUN;
    end else if (state_q == HALT) begin
      pc_d = pc_q;
    end else if (bus.StallF) begin
      pc_d = pc_q;
    end else if (!in_range) begin
      state_d = HALT;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Next IF/ID contents; flush and redirect bubble, stall holds, out-of-window fetches bubble
  always_comb begin
    instr_d = instr_q;
    pc8_d   = pc8_q;
    valid_d = valid_q;
    count_d = count_q;
    if (bus.FlushD || bus.BranchTakenE) begin
      instr_d = 32'd0;
      pc8_d   = 32'd0;
      valid_d = 1'b0;
    end else if (bus.StallD) begin
      instr_d = instr_q;
      pc8_d   = pc8_q;
      valid_d = valid_q;
    end else if ((state_q == HALT) || !in_range) begin
      instr_d = 32'd0;
      pc8_d   = 32'd0;
      valid_d = 1'b0;
    end else begin
      instr_d = bus.InstrF;
      pc8_d   = pc_q + 32'd8;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  // All state registers, cleared immediately on reset
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc8_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc8_q   <= pc8_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign bus.PCF        = pc_q;
  assign bus.InstrD     = instr_q;
  assign bus.PCPlus8D   = pc8_q;
  assign bus.ValidD     = valid_q;
  assign bus.Halted     = (state_q == HALT);
  assign bus.FetchCount = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios from the test plan
// plus randomized control traffic checked against a cycle model of the rules.
module tb_fetch_stage;

  localparam logic [31:0] LIMIT = 32'h0000_01FC;

  logic CLK;
  logic Reset;
  int   tests;
  int   fails;

  logic [31:0] mem [128];

  fetch_stage_if bus();

  fetch_stage dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  // Combinational instruction memory
  assign bus.InstrF = (bus.PCF <= LIMIT) ? mem[bus.PCF[8:2]] : 32'h0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc8, m_count;
  logic        m_valid, m_halt;

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pc8   = 32'h0;
    m_valid = 1'b0;
    m_halt  = 1'b0;
    m_count = 32'h0;
  endtask

  // Advance DUT and model by one clock edge; leaves time 1 unit after the edge
  task automatic step();
    logic [31:0] n_pc, n_instr, n_pc8, n_count, word;
    logic        n_valid, n_halt, inr;
    inr     = (m_pc <= LIMIT);
    word    = inr ? mem[m_pc[8:2]] : 32'h0;
    n_pc    = m_pc;
    n_halt  = m_halt;
    n_instr = m_instr;
    n_pc8   = m_pc8;
    n_valid = m_valid;
    n_count = m_count;
    if (bus.BranchTakenE) begin
      n_pc   = bus.BranchTargetE & 32'hFFFF_FFFC;
      n_halt = 1'b0;
    end else if (!m_halt && !bus.StallF) begin
      if (!inr) n_halt = 1'b1;
      else      n_pc   = m_pc + 32'd4;
    end
    if (bus.FlushD || bus.BranchTakenE || (!bus.StallD && (m_halt || !inr))) begin
      n_instr = 32'h0;
      n_pc8   = 32'h0;
      n_valid = 1'b0;
    end else if (!bus.StallD) begin
      n_instr = word;
      n_pc8   = m_pc + 32'd8;
      n_valid = 1'b1;
      n_count = m_count + 32'd1;
    end
    @(posedge CLK);
    #1;
    m_pc    = n_pc;
    m_halt  = n_halt;
    m_instr = n_instr;
    m_pc8   = n_pc8;
    m_valid = n_valid;
    m_count = n_count;
  endtask

  task automatic clear_inputs();
    bus.StallF        = 1'b0;
    bus.StallD        = 1'b0;
    bus.FlushD        = 1'b0;
    bus.BranchTakenE  = 1'b0;
    bus.BranchTargetE = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    tests++;
    if ({bus.PCF, bus.InstrD, bus.PCPlus8D, bus.ValidD, bus.Halted, bus.FetchCount} !== 98'h0) begin
      fails++;
      $display("[TB] FAIL reset_state: PCF=%h InstrD=%h PC8=%h V=%b H=%b cnt=%0d, want all zero",
               bus.PCF, bus.InstrD, bus.PCPlus8D, bus.ValidD, bus.Halted, bus.FetchCount);
    end
    Reset = 1'b0;
  endtask

  task automatic test_fib();
    tests++;
    if (bus.PCF !== 32'h0) begin
      fails++;
      $display("[TB] FAIL fib_pc0: PCF=%h want 00000000", bus.PCF);
    end
    step();
    tests++;
    if (bus.PCF !== 32'h4 || bus.InstrD !== 32'hE2000000 || bus.PCPlus8D !== 32'h8 || bus.ValidD !== 1'b1) begin
      fails++;
      $display("[TB] FAIL fib_cycle1: PCF=%h InstrD=%h PC8=%h V=%b want 4 E2000000 8 1",
               bus.PCF, bus.InstrD, bus.PCPlus8D, bus.ValidD);
    end
    step();
    tests++;
    if (bus.PCF !== 32'h8 || bus.InstrD !== 32'hE2801001 || bus.FetchCount !== 32'd2) begin
      fails++;
      $display("[TB] FAIL fib_cycle2: PCF=%h InstrD=%h cnt=%0d want 8 E2801001 2",
               bus.PCF, bus.InstrD, bus.FetchCount);
    end
  endtask

  task automatic test_stall();
    repeat (2) step();
    tests++;
    if (bus.PCF !== 32'h10 || bus.InstrD !== 32'hE2844001 || bus.FetchCount !== 32'd4) begin
      fails++;
      $display("[TB] FAIL stall_pre: PCF=%h InstrD=%h cnt=%0d want 10 E2844001 4",
               bus.PCF, bus.InstrD, bus.FetchCount);
    end
    bus.StallF = 1'b1;
    bus.StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (bus.PCF !== 32'h10 || bus.InstrD !== 32'hE2844001 || bus.ValidD !== 1'b1 || bus.FetchCount !== 32'd4) begin
        fails++;
        $display("[TB] FAIL stall_hold%0d: PCF=%h InstrD=%h V=%b cnt=%0d want 10 E2844001 1 4",
                 i, bus.PCF, bus.InstrD, bus.ValidD, bus.FetchCount);
      end
    end
    clear_inputs();
    step();
    tests++;
    if (bus.PCF !== 32'h14 || bus.InstrD !== 32'hE5841000 || bus.ValidD !== 1'b1 || bus.FetchCount !== 32'd5) begin
      fails++;
      $display("[TB] FAIL stall_release: PCF=%h InstrD=%h V=%b cnt=%0d want 14 E5841000 1 5",
               bus.PCF, bus.InstrD, bus.ValidD, bus.FetchCount);
    end
  endtask

  task automatic test_redirect();
    int n;
    n = 0;
    while (bus.PCF !== 32'h40 && n < 64) begin
      step();
      n++;
    end
    tests++;
    if (bus.PCF !== 32'h40) begin
      fails++;
      $display("[TB] FAIL redirect_reach: PCF=%h want 00000040 within 64 cycles", bus.PCF);
    end
    bus.BranchTakenE  = 1'b1;
    bus.BranchTargetE = 32'h20;
    step();
    clear_inputs();
    tests++;
    if (bus.PCF !== 32'h20 || bus.ValidD !== 1'b0) begin
      fails++;
      $display("[TB] FAIL redirect_bubble: PCF=%h V=%b want 20 0", bus.PCF, bus.ValidD);
    end
    step();
    tests++;
    if (bus.InstrD !== 32'hE0812000 || bus.PCPlus8D !== 32'h28 || bus.ValidD !== 1'b1 || bus.PCF !== 32'h24) begin
      fails++;
      $display("[TB] FAIL redirect_target: InstrD=%h PC8=%h V=%b PCF=%h want E0812000 28 1 24",
               bus.InstrD, bus.PCPlus8D, bus.ValidD, bus.PCF);
    end
  endtask

  task automatic test_simultaneous();
    bus.StallF        = 1'b1;
    bus.StallD        = 1'b1;
    bus.BranchTakenE  = 1'b1;
    bus.BranchTargetE = 32'h22;
    step();
    clear_inputs();
    tests++;
    if (bus.PCF !== 32'h20 || bus.ValidD !== 1'b0) begin
      fails++;
      $display("[TB] FAIL branch_over_stall: PCF=%h V=%b want 20 0", bus.PCF, bus.ValidD);
    end
    step();
    bus.FlushD = 1'b1;
    bus.StallD = 1'b1;
    step();
    clear_inputs();
    tests++;
    if (bus.ValidD !== 1'b0 || bus.InstrD !== 32'h0 || bus.PCF !== 32'h28) begin
      fails++;
      $display("[TB] FAIL flush_over_stall: V=%b InstrD=%h PCF=%h want 0 0 28",
               bus.ValidD, bus.InstrD, bus.PCF);
    end
  endtask

  task automatic test_halt();
    int n;
    logic [31:0] cnt;
    bus.BranchTakenE  = 1'b1;
    bus.BranchTargetE = 32'h1F0;
    step();
    clear_inputs();
    n = 0;
    while (bus.PCF !== 32'h200 && n < 16) begin
      step();
      n++;
    end
    tests++;
    if (bus.PCF !== 32'h200 || bus.Halted !== 1'b0 || bus.InstrD !== mem[127]) begin
      fails++;
      $display("[TB] FAIL halt_reach: PCF=%h H=%b InstrD=%h want 200 0 %h",
               bus.PCF, bus.Halted, bus.InstrD, mem[127]);
    end
    cnt = bus.FetchCount;
    step();
    tests++;
    if (bus.Halted !== 1'b1 || bus.PCF !== 32'h200 || bus.ValidD !== 1'b0) begin
      fails++;
      $display("[TB] FAIL halt_entry: H=%b PCF=%h V=%b want 1 200 0", bus.Halted, bus.PCF, bus.ValidD);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (bus.ValidD !== 1'b0 || bus.PCF !== 32'h200 || bus.Halted !== 1'b1 || bus.FetchCount !== cnt) begin
        fails++;
        $display("[TB] FAIL halt_hold%0d: V=%b PCF=%h H=%b cnt=%0d want 0 200 1 %0d",
                 i, bus.ValidD, bus.PCF, bus.Halted, bus.FetchCount, cnt);
      end
    end
    bus.BranchTakenE  = 1'b1;
    bus.BranchTargetE = 32'h0;
    step();
    clear_inputs();
    tests++;
    if (bus.Halted !== 1'b0 || bus.PCF !== 32'h0 || bus.ValidD !== 1'b0) begin
      fails++;
      $display("[TB] FAIL halt_exit: H=%b PCF=%h V=%b want 0 0 0", bus.Halted, bus.PCF, bus.ValidD);
    end
    step();
    tests++;
    if (bus.ValidD !== 1'b1 || bus.InstrD !== 32'hE2000000 || bus.PCF !== 32'h4) begin
      fails++;
      $display("[TB] FAIL halt_resume: V=%b InstrD=%h PCF=%h want 1 E2000000 4",
               bus.ValidD, bus.InstrD, bus.PCF);
    end
  endtask

  task automatic test_random();
    logic st;
    for (int i = 0; i < 600; i++) begin
      st                = ($urandom_range(0, 4) == 0);
      bus.StallF        = ($urandom_range(0, 9) == 0) ? ~st : st;
      bus.StallD        = st;
      bus.FlushD        = ($urandom_range(0, 9) == 0);
      bus.BranchTakenE  = ($urandom_range(0, 11) == 0);
      bus.BranchTargetE = ($urandom_range(0, 3) == 0) ? $urandom_range(32'h1C0, 32'h23F)
                                                      : $urandom_range(0, 32'h1FF);
      step();
      tests++;
      if ({bus.PCF, bus.InstrD, bus.PCPlus8D, bus.ValidD, bus.Halted, bus.FetchCount} !==
          {m_pc, m_instr, m_pc8, m_valid, m_halt, m_count}) begin
        fails++;
        $display("[TB] FAIL random_cycle%0d: PCF=%h InstrD=%h PC8=%h V=%b H=%b cnt=%0d want %h %h %h %b %b %0d",
                 i, bus.PCF, bus.InstrD, bus.PCPlus8D, bus.ValidD, bus.Halted, bus.FetchCount,
                 m_pc, m_instr, m_pc8, m_valid, m_halt, m_count);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    int n;
    bus.BranchTakenE  = 1'b1;
    bus.BranchTargetE = 32'h20;
    step();
    clear_inputs();
    n = 0;
    while (bus.PCF !== 32'h30 && n < 16) begin
      step();
      n++;
    end
    tests++;
    if (bus.PCF !== 32'h30 || bus.FetchCount === 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_mid_reach: PCF=%h cnt=%0d want 30 and nonzero", bus.PCF, bus.FetchCount);
    end
    #2;
    Reset = 1'b1;
    #1;
    tests++;
    if (bus.PCF !== 32'h0 || bus.ValidD !== 1'b0 || bus.FetchCount !== 32'h0 || bus.Halted !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_async: PCF=%h V=%b cnt=%0d H=%b want 0 0 0 0",
               bus.PCF, bus.ValidD, bus.FetchCount, bus.Halted);
    end
    @(negedge CLK);
    Reset = 1'b0;
    model_reset();
    step();
    tests++;
    if (bus.PCF !== 32'h4 || bus.InstrD !== 32'hE2000000 || bus.ValidD !== 1'b1 || bus.FetchCount !== 32'd1) begin
      fails++;
      $display("[TB] FAIL reset_refetch: PCF=%h InstrD=%h V=%b cnt=%0d want 4 E2000000 1 1",
               bus.PCF, bus.InstrD, bus.ValidD, bus.FetchCount);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[0] = 32'hE2000000;
    mem[1] = 32'hE2801001;
    mem[3] = 32'hE2844001;
    mem[4] = 32'hE5841000;
    mem[8] = 32'hE0812000;
    Reset  = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_fib();
    test_stall();
    test_redirect();
    test_simultaneous();
    test_halt();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule
